// File: rtl/kbd_matrix_pkg.sv
// Shared constants and types for the PET keyboard matrix block.
// No ports; imported by the interface, the PIA snoop and the top.
package kbd_matrix_pkg;

    localparam int unsigned KBD_ROW_COUNT         = 10;
    localparam int unsigned KBD_ADDR_WIDTH        = 4;
    localparam int unsigned KBD_COL_WIDTH         = 8;
    localparam int unsigned KBD_ROW_SEL_WIDTH     = 4;
    localparam int unsigned PIA_RS_WIDTH          = 2;
    localparam int unsigned PIA_CR_DDR_ACCESS_BIT = 2;

    // Active-low key image: all ones means no key pressed.
    localparam logic [KBD_COL_WIDTH-1:0] KBD_NO_KEY = 8'hFF;

    typedef logic [KBD_COL_WIDTH-1:0] kbd_row_t;

    // 6520 register select decode.
    typedef enum logic [PIA_RS_WIDTH-1:0] {
        PIA_PORTA = 2'd0,
        PIA_CRA   = 2'd1,
        PIA_PORTB = 2'd2,
        PIA_CRB   = 2'd3
    } pia_rs_e;

endpackage

// File: rtl/kbd_matrix_if.sv
// Bus bundle for kbd_matrix: Wishbone slave port (MCU side), PIA1 snoop inputs
// (CPU side) and the keyboard outputs. Signal names are from the slave's view.
//   slave  : used by kbd_matrix
//   master : used by whatever drives the Wishbone and CPU sides
interface kbd_matrix_if import kbd_matrix_pkg::*; #(
    parameter int unsigned ADDR_WIDTH = KBD_ADDR_WIDTH
);
    logic [ADDR_WIDTH-1:0]    wb_adr_i;
    logic [KBD_COL_WIDTH-1:0] wb_dat_i;
    logic [KBD_COL_WIDTH-1:0] wb_dat_o;
    logic                     wb_we_i;
    logic                     wb_cyc_i;
    logic                     wb_stb_i;
    logic                     wb_ack_o;

    logic                     pia1_cs_i;
    logic [PIA_RS_WIDTH-1:0]  pia_rs_i;
    logic                     cpu_we_i;
    logic                     cpu_strobe_i;
    logic [7:0]               cpu_data_i;

    logic [KBD_COL_WIDTH-1:0] kbd_cols_o;
    logic                     kbd_oe_o;
    logic [3:0]               row_sel_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  pia1_cs_i, pia_rs_i, cpu_we_i, cpu_strobe_i, cpu_data_i,
        output wb_dat_o, wb_ack_o, kbd_cols_o, kbd_oe_o, row_sel_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output pia1_cs_i, pia_rs_i, cpu_we_i, cpu_strobe_i, cpu_data_i,
        input  wb_dat_o, wb_ack_o, kbd_cols_o, kbd_oe_o, row_sel_o
    );

endinterface

// File: rtl/kbd_matrix_pia_ctrl_snoop.sv
// Passive snoop of CPU writes to a 6520 PIA: captures CRA, CRB and the port A
// output value (row select), and decodes when a port B read should be served
// by us. Reusable for other PIAs that scan a matrix.
//   clk, rst_n    : clock, async active-low reset
//   cs, rs, we    : PIA chip select, register select, CPU write/read
//   strobe, data  : CPU data-valid pulse and write data
//   row_sel       : registered row select
//   row_sel_next  : value row_sel takes at the next edge (write-through path)
//   oe            : combinational port B read enable
module kbd_matrix_pia_ctrl_snoop import kbd_matrix_pkg::*; (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cs,
    input  logic [PIA_RS_WIDTH-1:0]      rs,
    input  logic                         we,
    input  logic                         strobe,
    input  logic [7:0]                   data,
    output logic [KBD_ROW_SEL_WIDTH-1:0] row_sel,
    output logic [KBD_ROW_SEL_WIDTH-1:0] row_sel_next,
    output logic                         oe
);
    logic [7:0]                   cra_q, cra_d;
    logic [7:0]                   crb_q, crb_d;
    logic [KBD_ROW_SEL_WIDTH-1:0] row_sel_q, row_sel_d;
    logic                         wr;

    assign wr = strobe & cs & we;

    always_comb begin
        cra_d     = cra_q;
        crb_d     = crb_q;
        row_sel_d = row_sel_q;
        if (wr) begin
            unique case (pia_rs_e'(rs))
                PIA_CRA:   cra_d = data;
                PIA_CRB:   crb_d = data;
                // With the DDR-access bit clear the write lands in DDRA instead.
                PIA_PORTA: if (cra_q[PIA_CR_DDR_ACCESS_BIT]) row_sel_d = data[KBD_ROW_SEL_WIDTH-1:0];
                PIA_PORTB: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cra_q     <= '0;
            crb_q     <= '0;
            row_sel_q <= '0;
        end else begin
            cra_q     <= cra_d;
            crb_q     <= crb_d;
            row_sel_q <= row_sel_d;
        end
    end

    assign row_sel      = row_sel_q;
    assign row_sel_next = row_sel_d;
    assign oe = cs & ~we & (pia_rs_e'(rs) == PIA_PORTB) & crb_q[PIA_CR_DDR_ACCESS_BIT];

    // Remaining control-register bits are kept for other PIA functions.
    logic unused_cr;
    assign unused_cr = ^{cra_q, crb_q};

endmodule

// File: rtl/kbd_matrix.sv
// PET keyboard matrix image. The MCU writes rows through a Wishbone slave; the
// CPU's PIA1 accesses are snooped to present the selected row on port B.
// Keys are active-low (0 = pressed).
//   sys_clock_i   : system clock
//   sys_reset_n_i : async active-low reset
//   bus           : kbd_matrix_if.slave (Wishbone, PIA1 snoop, keyboard outputs)
module kbd_matrix import kbd_matrix_pkg::*; #(
    parameter int unsigned ROW_COUNT  = KBD_ROW_COUNT,
    parameter int unsigned ADDR_WIDTH = KBD_ADDR_WIDTH
) (
    input logic          sys_clock_i,
    input logic          sys_reset_n_i,
    kbd_matrix_if.slave  bus
);
    kbd_row_t                     rows_q [ROW_COUNT];
    kbd_row_t                     rows_d [ROW_COUNT];
    kbd_row_t                     rd_data;
    kbd_row_t                     dat_q;
    kbd_row_t                     cols_q, cols_d;
    logic                         ack_q;
    logic                         wb_req;
    logic [KBD_ROW_SEL_WIDTH-1:0] row_sel, row_sel_next;

    kbd_matrix_pia_ctrl_snoop u_snoop (
        .clk          (sys_clock_i),
        .rst_n        (sys_reset_n_i),
        .cs           (bus.pia1_cs_i),
        .rs           (bus.pia_rs_i),
        .we           (bus.cpu_we_i),
        .strobe       (bus.cpu_strobe_i),
        .data         (bus.cpu_data_i),
        .row_sel      (row_sel),
        .row_sel_next (row_sel_next),
        .oe           (bus.kbd_oe_o)
    );

    // A request is not accepted in its own ack cycle, so a held stb acks every other cycle.
    assign wb_req = bus.wb_cyc_i & bus.wb_stb_i & ~ack_q;

    always_comb begin
        rows_d  = rows_q;
        rd_data = KBD_NO_KEY;
        // Addresses past the last row match nothing: reads give no-key, writes drop.
        for (int r = 0; r < ROW_COUNT; r++) begin
            if (bus.wb_adr_i == r[ADDR_WIDTH-1:0]) begin
                rd_data = rows_q[r];
                if (wb_req && bus.wb_we_i) rows_d[r] = bus.wb_dat_i;
            end
        end
        // Columns come from next-state values so a same-cycle row write or
        // row-select change is visible one cycle later.
        cols_d = KBD_NO_KEY;
        for (int r = 0; r < ROW_COUNT; r++) begin
            if (row_sel_next == r[KBD_ROW_SEL_WIDTH-1:0]) cols_d = rows_d[r];
        end
    end

    always_ff @(posedge sys_clock_i or negedge sys_reset_n_i) begin
        if (!sys_reset_n_i) begin
            for (int r = 0; r < ROW_COUNT; r++) rows_q[r] <= KBD_NO_KEY;
            ack_q  <= 1'b0;
            dat_q  <= KBD_NO_KEY;
            cols_q <= KBD_NO_KEY;
        end else begin
            rows_q <= rows_d;
            ack_q  <= wb_req;
            if (wb_req && !bus.wb_we_i) dat_q <= rd_data;
            cols_q <= cols_d;
        end
    end

    assign bus.wb_ack_o   = ack_q;
    assign bus.wb_dat_o   = dat_q;
    assign bus.kbd_cols_o = cols_q;
    assign bus.row_sel_o  = row_sel;

endmodule
